// File: rtl/danger_scheduler_if.sv
// Bus between the game-state logic (master) and the obstacle scheduler (slave).
// The slot outputs carry the renderer's per-slot position, type and enable.
interface danger_scheduler_if;
  logic       game_run;
  logic       clear;
  logic       tick;
  logic [3:0] speed;
  logic [9:0] new_danger_pos1;
  logic [9:0] new_danger_pos2;
  logic [9:0] new_danger_pos3;
  logic [2:0] danger_type1;
  logic [2:0] danger_type2;
  logic [2:0] danger_type3;
  logic       danger_en1;
  logic       danger_en2;
  logic       danger_en3;

  modport master (
    output game_run, clear, tick, speed,
    input  new_danger_pos1, new_danger_pos2, new_danger_pos3,
    input  danger_type1, danger_type2, danger_type3,
    input  danger_en1, danger_en2, danger_en3
  );

  modport slave (
    input  game_run, clear, tick, speed,
    output new_danger_pos1, new_danger_pos2, new_danger_pos3,
    output danger_type1, danger_type2, danger_type3,
    output danger_en1, danger_en2, danger_en3
  );
endinterface

// File: rtl/danger_scheduler.sv
// Obstacle slot scheduler: spawns obstacles at pseudo-random intervals and types,
// scrolls them left on each game tick and retires them at the left edge.
//
// state | meaning
// IDLE  | no game in progress; slots and spawn timer held
// RUN   | ticks move obstacles, count down the spawn timer and spawn
// HALT  | game paused; everything frozen until game_run returns
module danger_scheduler #(
  parameter int          SPAWN_X   = 720,
  parameter int          MIN_GAP   = 200,
  parameter int          MIN_TICKS = 40,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic               clk,
  input logic               rst,
  danger_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [2:0] TYPE_NOTHING = 3'd5;
  localparam logic [9:0] SPAWN_POS    = 10'(SPAWN_X);
  localparam logic [9:0] GAP_LIMIT    = 10'(SPAWN_X - MIN_GAP);
  localparam logic [7:0] GAP_BASE     = 8'(MIN_TICKS);

  state_t          state;
  logic [15:0]     lfsr;
  logic [7:0]      gap_cnt;
  logic [1:0]      newest;
  logic [2:0][9:0] pos_q;
  logic [2:0][2:0] type_q;
  logic [2:0]      en_q;

  logic [2:0][9:0] nx_pos;
  logic [2:0][2:0] nx_type;
  logic [2:0]      nx_en;
  logic [1:0]      free_idx;
  logic            free_found;
  logic [9:0]      newest_pos;
  logic            spacing_ok;
  logic            spawn_go;
  logic [2:0]      spawn_type;
  logic [9:0]      step;

  assign step       = {6'd0, bus.speed};
  assign spawn_type = (lfsr[2:0] >= 3'd5) ? (lfsr[2:0] - 3'd3) : lfsr[2:0];

  // Free-slot search uses pre-tick enables so a slot retired this tick is not reused yet.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (!en_q[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  // Post-move slot values, then the optional spawn overlaid on the chosen free slot.
  always_comb begin
    nx_pos  = pos_q;
    nx_type = type_q;
    nx_en   = en_q;
    for (int i = 0; i < 3; i++) begin
      if (en_q[i]) begin
        if (pos_q[i] <= step) begin
          nx_en[i]   = 1'b0;
          nx_pos[i]  = 10'd0;
          nx_type[i] = TYPE_NOTHING;
        end else begin
          nx_pos[i] = pos_q[i] - step;
        end
      end
    end

    case (newest)
      2'd1:    newest_pos = nx_pos[1];
      2'd2:    newest_pos = nx_pos[2];
      default: newest_pos = nx_pos[0];
    endcase
    spacing_ok = (nx_en == 3'b000) || (newest_pos <= GAP_LIMIT);
    spawn_go   = (state == RUN) && bus.tick && (gap_cnt == 8'd0) &&
                 free_found && spacing_ok;

    if (spawn_go) begin
      nx_en[free_idx]   = 1'b1;
      nx_pos[free_idx]  = SPAWN_POS;
      nx_type[free_idx] = spawn_type;
    end
  end

  // Control FSM, LFSR, spawn timer and slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= SEED;
      gap_cnt <= GAP_BASE;
      newest  <= 2'd0;
      pos_q   <= '0;
      type_q  <= {3{TYPE_NOTHING}};
      en_q    <= 3'b000;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (bus.clear) begin
        state   <= IDLE;
        gap_cnt <= GAP_BASE;
        newest  <= 2'd0;
        pos_q   <= '0;
        type_q  <= {3{TYPE_NOTHING}};
        en_q    <= 3'b000;
      end else begin
        case (state)
          IDLE: if (bus.game_run) state <= RUN;
          HALT: if (bus.game_run) state <= RUN;
          RUN: begin
            if (!bus.game_run) state <= HALT;
            if (bus.tick) begin
              pos_q  <= nx_pos;
              type_q <= nx_type;
              en_q   <= nx_en;
              if (spawn_go) begin
                gap_cnt <= GAP_BASE + {4'd0, lfsr[7:4]};
                newest  <= free_idx;
              end else if (gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.new_danger_pos1 = pos_q[0];
  assign bus.new_danger_pos2 = pos_q[1];
  assign bus.new_danger_pos3 = pos_q[2];
  assign bus.danger_type1    = type_q[0];
  assign bus.danger_type2    = type_q[1];
  assign bus.danger_type3    = type_q[2];
  assign bus.danger_en1      = en_q[0];
  assign bus.danger_en2      = en_q[1];
  assign bus.danger_en3      = en_q[2];

endmodule

// File: tb/tb_danger_scheduler.sv
// Directed bench for danger_scheduler: walks obstacles through spawn, spacing,
// full-slot, retire, pause, clear and reset scenarios with hand-computed positions.
module tb_danger_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m_lfsr;
  logic [2:0]  last_t;
  logic [2:0]  t1, t2, t3;
  int          n_chk  = 0;
  int          n_pass = 0;

  danger_scheduler_if bus ();

  danger_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR, used only to predict spawned obstacle types.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [2:0] tmap(input logic [2:0] t);
    return (t >= 3'd5) ? t - 3'd3 : t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_slot(input int n, input logic en, input logic [9:0] pos,
                          input logic [2:0] typ);
    case (n)
      1: begin
        chk("en1", 32'(bus.danger_en1), 32'(en));
        chk("pos1", 32'(bus.new_danger_pos1), 32'(pos));
        chk("type1", 32'(bus.danger_type1), 32'(typ));
      end
      2: begin
        chk("en2", 32'(bus.danger_en2), 32'(en));
        chk("pos2", 32'(bus.new_danger_pos2), 32'(pos));
        chk("type2", 32'(bus.danger_type2), 32'(typ));
      end
      default: begin
        chk("en3", 32'(bus.danger_en3), 32'(en));
        chk("pos3", 32'(bus.new_danger_pos3), 32'(pos));
        chk("type3", 32'(bus.danger_type3), 32'(typ));
      end
    endcase
  endtask

  task automatic chk_all_reset();
    for (int i = 1; i <= 3; i++) chk_slot(i, 1'b0, 10'd0, 3'd5);
  endtask

  // One tick pulse; last_t is the type a spawn on this tick would take.
  task automatic do_tick(input logic [3:0] spd);
    @(negedge clk);
    bus.speed = spd;
    bus.tick  = 1'b1;
    last_t    = tmap(m_lfsr[2:0]);
    @(negedge clk);
    bus.tick  = 1'b0;
  endtask

  task automatic tick_n(input int n, input logic [3:0] spd);
    for (int k = 0; k < n; k++) do_tick(spd);
  endtask

  task automatic set_run(input logic v);
    @(negedge clk);
    bus.game_run = v;
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    bus.game_run = 1'b0;
    bus.clear    = 1'b0;
    bus.tick     = 1'b0;
    bus.speed    = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_reset();

    // Ticks in IDLE are ignored, so the spawn timer still holds its full count.
    tick_n(5, 4'd4);
    chk("idle_no_spawn", 32'(bus.danger_en1), 32'd0);

    set_run(1'b1);
    tick_n(40, 4'd4);
    chk("gap_not_yet", 32'(bus.danger_en1), 32'd0);
    do_tick(4'd4);
    t1 = last_t;
    chk_slot(1, 1'b1, 10'd720, t1);
    chk("one_slot_only", 32'({bus.danger_en3, bus.danger_en2}), 32'd0);
    do_tick(4'd4);
    chk("first_move", 32'(bus.new_danger_pos1), 32'd716);

    // Exhaust the timer without motion; newest at 716 blocks spawning.
    tick_n(60, 4'd0);
    chk_slot(1, 1'b1, 10'd716, t1);
    chk("spacing_716", 32'(bus.danger_en2), 32'd0);
    tick_n(12, 4'd15);
    chk("pos_536", 32'(bus.new_danger_pos1), 32'd536);
    do_tick(4'd6);
    chk("pos_530", 32'(bus.new_danger_pos1), 32'd530);
    chk("spacing_530", 32'(bus.danger_en2), 32'd0);
    do_tick(4'd10);
    t2 = last_t;
    chk("pos_520", 32'(bus.new_danger_pos1), 32'd520);
    chk_slot(2, 1'b1, 10'd720, t2);

    // Third obstacle once slot2 reaches the spacing limit.
    tick_n(60, 4'd0);
    chk("spacing_slot2", 32'(bus.danger_en3), 32'd0);
    tick_n(20, 4'd10);
    t3 = last_t;
    chk_slot(1, 1'b1, 10'd320, t1);
    chk_slot(2, 1'b1, 10'd520, t2);
    chk_slot(3, 1'b1, 10'd720, t3);

    // All slots busy: timer sits at zero, nothing changes.
    tick_n(60, 4'd0);
    chk("full_en", 32'({bus.danger_en3, bus.danger_en2, bus.danger_en1}), 32'd7);
    chk("full_pos3", 32'(bus.new_danger_pos3), 32'd720);
    tick_n(20, 4'd10);
    chk("full_pos1", 32'(bus.new_danger_pos1), 32'd120);
    chk("full_pos3b", 32'(bus.new_danger_pos3), 32'd520);
    tick_n(7, 4'd15);
    do_tick(4'd9);
    chk("pos_6", 32'(bus.new_danger_pos1), 32'd6);
    do_tick(4'd4);
    chk_slot(1, 1'b1, 10'd2, t1);
    do_tick(4'd4);
    chk_slot(1, 1'b0, 10'd0, 3'd5);
    chk("retire_others", 32'({bus.danger_en3, bus.danger_en2}), 32'd3);
    chk("retire_pos2", 32'(bus.new_danger_pos2), 32'd198);
    do_tick(4'd4);
    t1 = last_t;
    chk_slot(1, 1'b1, 10'd720, t1);
    chk_slot(2, 1'b1, 10'd194, t2);
    chk_slot(3, 1'b1, 10'd394, t3);

    // Pause freezes everything, resuming restores motion.
    set_run(1'b0);
    tick_n(10, 4'd4);
    chk_slot(1, 1'b1, 10'd720, t1);
    chk_slot(2, 1'b1, 10'd194, t2);
    chk_slot(3, 1'b1, 10'd394, t3);
    set_run(1'b1);
    do_tick(4'd4);
    chk("resume_pos1", 32'(bus.new_danger_pos1), 32'd716);
    chk("resume_pos3", 32'(bus.new_danger_pos3), 32'd390);

    // Clear wins over game_run and restarts the spawn timer.
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk_all_reset();
    @(negedge clk);
    tick_n(40, 4'd4);
    chk("clear_gap", 32'(bus.danger_en1), 32'd0);

    // Reset coinciding with a spawning tick.
    @(negedge clk);
    rst      = 1'b1;
    bus.tick = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    bus.tick = 1'b0;
    chk_all_reset();
    @(negedge clk);
    tick_n(41, 4'd4);
    chk_slot(1, 1'b1, 10'd720, last_t);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
